// File: rtl/ps2_pkg.sv
// Shared scan codes, FSM state encodings and the held-key flag bundle for the PS/2 decoder.
package ps2_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_AA    = 8'hAA;
  localparam logic [7:0] SC_FA    = 8'hFA;

  typedef enum logic [1:0] {SCAN_BASE, SCAN_EXT, SCAN_BRK, SCAN_EXT_BRK} scan_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;

  typedef struct packed {
    logic w;
    logic a;
    logic d;
    logic up;
    logic left;
    logic right;
  } keys_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// Synchronizes the PS/2 pins and assembles 11-bit frames into bytes.
// byte_valid/frame_err are single-cycle combinational pulses from the CHECK/timeout decisions.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;
  rx_state_t              state, state_nxt;
  logic [9:0]             shreg;
  logic [3:0]             bit_cnt;
  logic [15:0]            tmo_cnt;
  logic                   good;

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in   = data_sync[SYNC_STAGES-1];
  // shreg holds {stop, parity, data[7:0]} once all ten post-start bits are in
  assign good     = (^shreg[8:0]) & shreg[9];
  assign byte_out = shreg[7:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == RX_SHIFT && !fall) tmo_cnt <= tmo_cnt + 16'd1;
      else                            tmo_cnt <= '0;
      if (state == RX_IDLE) begin
        bit_cnt <= '0;
      end else if (state == RX_SHIFT && fall) begin
        shreg   <= {bit_in, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall && !bit_in) state_nxt = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (fall) begin
          if (bit_cnt == 4'd9) state_nxt = RX_CHECK;
        end else if (tmo_cnt == TIMEOUT_CYC - 16'd1) begin
          frame_err = 1'b1;
          state_nxt = RX_IDLE;
        end
      end
      RX_CHECK: begin
        byte_valid = good;
        frame_err  = ~good;
        state_nxt  = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 bytes into held-key flags for both players; all outputs registered,
// so code_valid lands two cycles after the stop-bit edge is detected.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w_key,
  output logic       a_key,
  output logic       d_key,
  output logic       up_key,
  output logic       left_key,
  output logic       right_key,
  output logic       code_valid,
  output logic [7:0] code_byte,
  output logic       frame_err
);

  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;
  scan_state_t scan_q, scan_d;
  keys_t       keys_q, keys_d;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (Clk),
    .reset_n    (Reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (rx_valid),
    .byte_out   (rx_byte),
    .frame_err  (rx_err)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      scan_q <= SCAN_BASE;
      keys_q <= '0;
    end else begin
      scan_q <= scan_d;
      keys_q <= keys_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      code_valid <= 1'b0;
      code_byte  <= '0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= rx_valid;
      frame_err  <= rx_err;
      if (rx_valid) code_byte <= rx_byte;
    end
  end

  always_comb begin
    scan_d = scan_q;
    keys_d = keys_q;
    if (rx_err) begin
      scan_d = SCAN_BASE;
    end else if (rx_valid) begin
      if (rx_byte == SC_AA) begin
        keys_d = '0;
        scan_d = SCAN_BASE;
      end else if (rx_byte != SC_FA) begin
        // every byte other than a prefix returns to BASE
        scan_d = SCAN_BASE;
        case (scan_q)
          SCAN_BASE: begin
            case (rx_byte)
              SC_E0:   scan_d   = SCAN_EXT;
              SC_F0:   scan_d   = SCAN_BRK;
              SC_W:    keys_d.w = 1'b1;
              SC_A:    keys_d.a = 1'b1;
              SC_D:    keys_d.d = 1'b1;
              default: ;
            endcase
          end
          SCAN_EXT: begin
            case (rx_byte)
              SC_F0:    scan_d       = SCAN_EXT_BRK;
              SC_UP:    keys_d.up    = 1'b1;
              SC_LEFT:  keys_d.left  = 1'b1;
              SC_RIGHT: keys_d.right = 1'b1;
              default:  ;
            endcase
          end
          SCAN_BRK: begin
            case (rx_byte)
              SC_W:    keys_d.w = 1'b0;
              SC_A:    keys_d.a = 1'b0;
              SC_D:    keys_d.d = 1'b0;
              default: ;
            endcase
          end
          SCAN_EXT_BRK: begin
            case (rx_byte)
              SC_UP:    keys_d.up    = 1'b0;
              SC_LEFT:  keys_d.left  = 1'b0;
              SC_RIGHT: keys_d.right = 1'b0;
              default:  ;
            endcase
          end
          default: scan_d = SCAN_BASE;
        endcase
      end
    end
  end

  assign w_key     = keys_q.w;
  assign a_key     = keys_q.a;
  assign d_key     = keys_q.d;
  assign up_key    = keys_q.up;
  assign left_key  = keys_q.left;
  assign right_key = keys_q.right;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed PS/2 frames with a scoreboard of expected bytes/errors and key flags.
module tb_ps2_key_decoder;

  localparam int          HALF = 20;
  localparam int          GAP  = 30;
  localparam int          SYNC = 2;
  localparam logic [15:0] TMO  = 16'd200;

  logic       Clk;
  logic       Reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       w_key, a_key, d_key, up_key, left_key, right_key;
  logic       code_valid;
  logic [7:0] code_byte;
  logic       frame_err;
  logic [5:0] keys;

  assign keys = {w_key, a_key, d_key, up_key, left_key, right_key};

  ps2_key_decoder #(
    .TIMEOUT_CYC (TMO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .w_key      (w_key),
    .a_key      (a_key),
    .d_key      (d_key),
    .up_key     (up_key),
    .left_key   (left_key),
    .right_key  (right_key),
    .code_valid (code_valid),
    .code_byte  (code_byte),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    logic [5:0] keys;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expected event
  always @(negedge Clk) begin
    if (Reset_n && (code_valid || frame_err)) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", {30'd0, code_valid, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, code_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) chk("code_byte", {24'd0, code_byte}, {24'd0, e.b});
        chk("key_flags", {26'd0, keys}, {26'd0, e.keys});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    int lat;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    wait_clk(HALF);
    ps2_clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= HALF; i++) begin
      wait_clk(1);
      if (code_valid && lat == 0) lat = i;
    end
    ps2_clk = 1'b1;
    // pin fall -> sync stages -> CHECK -> code_valid register
    if (!bad_par) chk("valid_latency", lat, SYNC + 2);
    wait_clk(GAP);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [5:0] k);
    sb.push_back('{1'b0, b, k});
    send_frame(b, 1'b0);
  endtask

  task automatic send_bad(input logic [7:0] b, input logic [5:0] k);
    sb.push_back('{1'b1, b, k});
    send_frame(b, 1'b1);
  endtask

  initial begin
    int n;
    Reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    chk("reset_state", {19'd0, code_valid, frame_err, code_byte, keys}, 32'd0);
    Reset_n = 1'b1;
    wait_clk(5);

    // keys = {w,a,d,up,left,right}
    send_byte(8'h1D, 6'b100000);
    send_byte(8'h1D, 6'b100000);
    send_byte(8'hF0, 6'b100000);
    send_byte(8'h1D, 6'b000000);

    send_byte(8'hE0, 6'b000000);
    send_byte(8'h6B, 6'b000010);
    send_byte(8'h6B, 6'b000010);
    send_byte(8'hE0, 6'b000010);
    send_byte(8'hF0, 6'b000010);
    send_byte(8'h6B, 6'b000000);
    send_byte(8'h6B, 6'b000000);
    send_byte(8'hE0, 6'b000000);
    send_byte(8'h1D, 6'b000000);

    // an error after E0 must drop the prefix, so 6B is keypad afterwards
    send_byte(8'hE0, 6'b000000);
    send_bad (8'h23, 6'b000000);
    send_byte(8'h6B, 6'b000000);

    // timeout: start bit + 4 data bits, then the clock stops
    sb.push_back('{1'b1, 8'h00, 6'b000000});
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    n = 0;
    for (int i = 1; i <= int'(TMO) + 50; i++) begin
      wait_clk(1);
      if (i == HALF) ps2_clk = 1'b1;
      if (frame_err) begin
        n = i;
        break;
      end
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    // TIMEOUT_CYC after edge detection, plus synchronizer and output register
    chk("timeout_latency", n, SYNC + int'(TMO) + 1);
    wait_clk(GAP);
    send_byte(8'h1C, 6'b010000);

    send_byte(8'h1D, 6'b110000);
    send_byte(8'h23, 6'b111000);
    send_byte(8'hE0, 6'b111000);
    send_byte(8'h75, 6'b111100);
    send_byte(8'hFA, 6'b111100);
    send_byte(8'hAA, 6'b000000);

    // reset in the middle of a frame
    send_byte(8'h1D, 6'b100000);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    Reset_n  = 1'b0;
    wait_clk(1);
    chk("reset_mid_frame", {19'd0, code_valid, frame_err, code_byte, keys}, 32'd0);
    Reset_n = 1'b1;
    wait_clk(2 * int'(TMO));
    send_byte(8'h1D, 6'b100000);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      wait_clk(1);
      n++;
    end
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
